// File: rtl/adc_pkg.sv
// Shared types and default constants for the ADC conversion sequencer.
// Imported by the interface, the synchroniser and the sequencer top.
package adc_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        IDLE      = 3'd1,
        CNV_HI    = 3'd2,
        CNV_LO    = 3'd3,
        DONE      = 3'd4
    } cnv_state_t;

    localparam int LOCK_WAIT_DEF = 1024;
    localparam int CNT_W_DEF     = 16;
    localparam int PER_W_DEF     = 16;

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Request/status bundle between a burst requester and adc_conv_sequencer.
// Clock, reset and the asynchronous PLL lock stay plain ports on the sequencer.
interface adc_conv_sequencer_if
    import adc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PER_W = PER_W_DEF
);

    // Handshake: a burst is accepted on a refclk edge where start=1 and ready=1;
    // num_samples/period/pulse_width are captured on that edge only. start with
    // ready=0 is dropped, never queued; ready stays low until the burst ends.
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic [PER_W-1:0] period;
    logic [7:0]       pulse_width;
    logic             clear_err;

    logic             ready;
    logic             busy;
    logic             adc_cnv;
    logic [CNT_W-1:0] sample_idx;
    logic             done;
    logic             lock_err;

    modport master (
        output start, num_samples, period, pulse_width, clear_err,
        input  ready, busy, adc_cnv, sample_idx, done, lock_err
    );

    modport slave (
        input  start, num_samples, period, pulse_width, clear_err,
        output ready, busy, adc_cnv, sample_idx, done, lock_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-high reset.
// Output lags the input by two clock edges.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// Qualifies the ADC PLL lock and issues bursts of adc_cnv pulses with
// programmable period, pulse width and sample count. PER_W must be >= 8.
module adc_conv_sequencer
    import adc_pkg::*;
#(
    parameter int LOCK_WAIT = LOCK_WAIT_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PER_W     = PER_W_DEF
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    adc_conv_sequencer_if.slave   bus,
    output cnv_state_t            dbg_state
);

    localparam int LW_W = ($clog2(LOCK_WAIT) < 1) ? 1 : $clog2(LOCK_WAIT);

    logic lk_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    cnv_state_t       state_q, state_d;
    logic [LW_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [PER_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [PER_W-1:0] hi_last_q, hi_last_d;
    logic [PER_W-1:0] lo_last_q, lo_last_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             lock_err_q, lock_err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             cnv_q, cnv_d;
    logic             done_q, done_d;

    // Clamped burst timing derived from the live request inputs.
    logic [PER_W-1:0] per_c;
    logic [PER_W-1:0] pw_ext;
    logic [PER_W-1:0] pw_nz;
    logic [PER_W-1:0] pw_c;
    logic             lock_lost;

    always_comb begin
        per_c  = (bus.period < PER_W'(2)) ? PER_W'(2) : bus.period;
        pw_ext = PER_W'(bus.pulse_width);
        pw_nz  = (pw_ext == '0) ? PER_W'(1) : pw_ext;
        pw_c   = (pw_nz >= per_c) ? (per_c - PER_W'(1)) : pw_nz;
    end

    assign lock_lost = (state_q != WAIT_LOCK) && !lk_s;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = '0;
        ph_cnt_d   = '0;
        hi_last_d  = hi_last_q;
        lo_last_d  = lo_last_q;
        num_d      = num_q;
        idx_d      = idx_q;
        lock_err_d = bus.clear_err ? 1'b0 : lock_err_q;

        case (state_q)
            WAIT_LOCK: begin
                if (lk_s) begin
                    if (lock_cnt_q == LW_W'(LOCK_WAIT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LW_W'(1);
                    end
                end
            end
            IDLE: begin
                if (bus.start) begin
                    num_d     = bus.num_samples;
                    hi_last_d = pw_c - PER_W'(1);
                    lo_last_d = per_c - pw_c - PER_W'(1);
                    idx_d     = '0;
                    state_d   = (bus.num_samples == '0) ? DONE : CNV_HI;
                end
            end
            CNV_HI: begin
                if (ph_cnt_q == hi_last_q) begin
                    state_d = CNV_LO;
                end else begin
                    ph_cnt_d = ph_cnt_q + PER_W'(1);
                end
            end
            CNV_LO: begin
                if (ph_cnt_q == lo_last_q) begin
                    if (idx_q == num_q - CNT_W'(1)) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = CNV_HI;
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PER_W'(1);
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss overrides everything, including a same-cycle clear_err.
        if (lock_lost) begin
            state_d    = WAIT_LOCK;
            idx_d      = '0;
            ph_cnt_d   = '0;
            lock_cnt_d = '0;
            lock_err_d = 1'b1;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CNV_HI) || (state_d == CNV_LO) || (state_d == DONE);
        cnv_d   = (state_d == CNV_HI);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            ph_cnt_q   <= '0;
            hi_last_q  <= '0;
            lo_last_q  <= '0;
            num_q      <= '0;
            idx_q      <= '0;
            lock_err_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            cnv_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            hi_last_q  <= hi_last_d;
            lo_last_q  <= lo_last_d;
            num_q      <= num_d;
            idx_q      <= idx_d;
            lock_err_q <= lock_err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            cnv_q      <= cnv_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.adc_cnv    = cnv_q;
    assign bus.sample_idx = idx_q;
    assign bus.done       = done_q;
    assign bus.lock_err   = lock_err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed self-checking bench for adc_conv_sequencer with LOCK_WAIT=16.
// Inputs change and outputs are sampled on the falling edge of refclk.
module tb_adc_conv_sequencer;
    import adc_pkg::*;

    localparam int LW = 16;
    localparam int CW = 16;
    localparam int PW = 16;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    cnv_state_t dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    adc_conv_sequencer_if #(.CNT_W(CW), .PER_W(PW)) bus ();

    adc_conv_sequencer #(
        .LOCK_WAIT (LW),
        .CNT_W     (CW),
        .PER_W     (PW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic drive_start(input int n, input int p, input int w);
        bus.num_samples = CW'(n);
        bus.period      = PW'(p);
        bus.pulse_width = 8'(w);
        bus.start       = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        bus.start = 1'b0;
        bus.num_samples = '0;
        bus.period = '0;
        bus.pulse_width = '0;
        bus.clear_err = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({bus.ready, bus.busy, bus.adc_cnv, bus.done, bus.lock_err} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.ready, bus.busy, bus.adc_cnv, bus.done, bus.lock_err});
        end
        tests_run++;
        if (bus.sample_idx !== 16'd0 || dbg_state !== WAIT_LOCK) begin
            tests_failed++;
            $display("FAIL reset_idx_state got idx=%0d state=%0d want 0/WAIT_LOCK",
                     bus.sample_idx, dbg_state);
        end
        rst = 1'b0;
        pll_locked = 1'b1;
        for (int k = 1; k <= LW + 1; k++) begin
            tick();
            tests_run++;
            if ({bus.ready, bus.busy, bus.adc_cnv, bus.done} !== 4'b0) begin
                tests_failed++;
                $display("FAIL lock_wait_quiet cycle %0d got %b want 0000", k,
                         {bus.ready, bus.busy, bus.adc_cnv, bus.done});
            end
        end
        tick();
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_lock got %b want 1 at cycle %0d", bus.ready, LW + 2);
        end
    endtask

    task automatic test_normal_burst();
        drive_start(3, 10, 4);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tests_run++;
            if (bus.adc_cnv !== ((c % 10) < 4) || bus.sample_idx !== 16'(c / 10) ||
                bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL normal_burst c=%0d got cnv=%b idx=%0d done=%b busy=%b want cnv=%b idx=%0d done=0 busy=1",
                         c, bus.adc_cnv, bus.sample_idx, bus.done, bus.busy, (c % 10) < 4, c / 10);
            end
            tick();
        end
        tests_run++;
        if (bus.done !== 1'b1 || bus.adc_cnv !== 1'b0 || bus.sample_idx !== 16'd0) begin
            tests_failed++;
            $display("FAIL normal_done got done=%b cnv=%b idx=%0d want 1/0/0",
                     bus.done, bus.adc_cnv, bus.sample_idx);
        end
        tick();
        tests_run++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_ready_return got ready=%b done=%b busy=%b want 1/0/0",
                     bus.ready, bus.done, bus.busy);
        end
    endtask

    task automatic test_clamp();
        int vn[2] = '{3, 2};
        int vp[2] = '{1, 5};
        int vw[2] = '{0, 9};
        int ep[2] = '{2, 5};
        int ew[2] = '{1, 4};
        for (int v = 0; v < 2; v++) begin
            drive_start(vn[v], vp[v], vw[v]);
            tick();
            bus.start = 1'b0;
            for (int c = 0; c < vn[v] * ep[v]; c++) begin
                tests_run++;
                if (bus.adc_cnv !== ((c % ep[v]) < ew[v]) || bus.sample_idx !== 16'(c / ep[v])) begin
                    tests_failed++;
                    $display("FAIL clamp v=%0d c=%0d got cnv=%b idx=%0d want cnv=%b idx=%0d",
                             v, c, bus.adc_cnv, bus.sample_idx, (c % ep[v]) < ew[v], c / ep[v]);
                end
                tick();
            end
            tests_run++;
            if (bus.done !== 1'b1) begin
                tests_failed++;
                $display("FAIL clamp_done v=%0d got %b want 1", v, bus.done);
            end
            tick();
            tests_run++;
            if (bus.ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL clamp_ready v=%0d got %b want 1", v, bus.ready);
            end
        end
    endtask

    task automatic test_zero_samples();
        drive_start(0, 10, 4);
        tick();
        bus.start = 1'b0;
        tests_run++;
        if (bus.done !== 1'b1 || bus.adc_cnv !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_done got done=%b cnv=%b busy=%b want 1/0/1",
                     bus.done, bus.adc_cnv, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.adc_cnv !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_ready got ready=%b done=%b cnv=%b want 1/0/0",
                     bus.ready, bus.done, bus.adc_cnv);
        end
    endtask

    task automatic test_back_to_back();
        drive_start(1, 4, 2);
        tick();
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (bus.adc_cnv !== (c < 2) || bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_first c=%0d got cnv=%b busy=%b ready=%b want %b/1/0",
                         c, bus.adc_cnv, bus.busy, bus.ready, c < 2);
            end
            tick();
        end
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_done got %b want 1", bus.done);
        end
        bus.num_samples = CW'(2);
        tick();
        tests_run++;
        if (bus.ready !== 1'b1 || bus.adc_cnv !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ready got ready=%b cnv=%b want 1/0", bus.ready, bus.adc_cnv);
        end
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tests_run++;
            if (bus.adc_cnv !== ((c % 4) < 2) || bus.sample_idx !== 16'(c / 4) || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_second c=%0d got cnv=%b idx=%0d busy=%b want %b/%0d/1",
                         c, bus.adc_cnv, bus.sample_idx, bus.busy, (c % 4) < 2, c / 4);
            end
            tick();
        end
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second_done got %b want 1", bus.done);
        end
        tick();
        tick();
        tests_run++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.adc_cnv !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_queue got ready=%b busy=%b cnv=%b want 1/0/0",
                     bus.ready, bus.busy, bus.adc_cnv);
        end
    endtask

    task automatic test_lock_loss();
        drive_start(3, 10, 4);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 11; c++) tick();
        tests_run++;
        if (bus.adc_cnv !== 1'b1 || bus.sample_idx !== 16'd1) begin
            tests_failed++;
            $display("FAIL loss_second_pulse got cnv=%b idx=%0d want 1/1", bus.adc_cnv, bus.sample_idx);
        end
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.adc_cnv !== 1'b0 || bus.lock_err !== 1'b1 || bus.busy !== 1'b0 ||
            bus.sample_idx !== 16'd0 || bus.ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL loss_abort got cnv=%b err=%b busy=%b idx=%0d ready=%b want 0/1/0/0/0",
                     bus.adc_cnv, bus.lock_err, bus.busy, bus.sample_idx, bus.ready);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            tests_run++;
            if (bus.done !== 1'b0 || bus.lock_err !== 1'b1 || bus.adc_cnv !== 1'b0) begin
                tests_failed++;
                $display("FAIL loss_quiet c=%0d got done=%b err=%b cnv=%b want 0/1/0",
                         c, bus.done, bus.lock_err, bus.adc_cnv);
            end
        end
        pll_locked = 1'b1;
        for (int k = 1; k <= LW + 1; k++) begin
            tick();
            tests_run++;
            if (bus.ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL relock_wait cycle %0d got ready=%b want 0", k, bus.ready);
            end
        end
        tick();
        tests_run++;
        if (bus.ready !== 1'b1 || bus.lock_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL relock_ready got ready=%b err=%b want 1/1", bus.ready, bus.lock_err);
        end
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        tests_run++;
        if (bus.lock_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_err got %b want 0", bus.lock_err);
        end
    endtask

    task automatic test_err_priority();
        pll_locked = 1'b0;
        tick();
        tick();
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        tests_run++;
        if (bus.lock_err !== 1'b1 || bus.ready !== 1'b0 || dbg_state !== WAIT_LOCK) begin
            tests_failed++;
            $display("FAIL err_priority got err=%b ready=%b state=%0d want 1/0/WAIT_LOCK",
                     bus.lock_err, bus.ready, dbg_state);
        end
        pll_locked = 1'b1;
        for (int k = 0; k < LW + 2; k++) tick();
        tests_run++;
        if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_priority_relock got ready=%b want 1", bus.ready);
        end
    endtask

    task automatic test_midburst_reset();
        drive_start(3, 10, 4);
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        tests_run++;
        if ({bus.ready, bus.busy, bus.adc_cnv, bus.done, bus.lock_err} !== 5'b0 ||
            bus.sample_idx !== 16'd0 || dbg_state !== WAIT_LOCK) begin
            tests_failed++;
            $display("FAIL midburst_reset got flags=%b idx=%0d state=%0d want 00000/0/WAIT_LOCK",
                     {bus.ready, bus.busy, bus.adc_cnv, bus.done, bus.lock_err},
                     bus.sample_idx, dbg_state);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_normal_burst();
        test_clamp();
        test_zero_samples();
        test_back_to_back();
        test_lock_loss();
        test_err_priority();
        test_midburst_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
